b11_serial_feeder: RTL and testbench

Upstream stage for the b11 datapath. It deframes 6-bit words from a serial line and buffers them in a small FIFO. It then presents each word on x_in with a one-cycle low pulse on stbi, which is the "take it" condition in b11's s_datain state. Consecutive words are separated by a guaranteed gap so that b11 finishes its s_spazio-to-s_dataout processing before the next word arrives.

---
 rtl/b11_serial_feeder.sv | 230 +++++++++++++++++++++++
 tb/tb_b11_serial_feeder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b11_serial_feeder.sv
// b11_serial_feeder: upstream feeder for the b11 datapath.
// Deframes 6-bit words from a serial line (start, d0..d5 LSB first,
// optional even parity, stop), queues them in a small FIFO and hands each
// word to b11 with a one-cycle low pulse on stbi, followed by a guaranteed
// high gap so b11 can finish processing before the next word.
// Optional feature macro: PARITY_CHECK_EN
//   defined   -> frames carry an even parity bit that is checked
//   undefined -> frames have no parity bit; only the stop bit is checked
module b11_serial_feeder #(
    parameter int DEPTH = 4,
    parameter int GAP   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ser_in,
    input  logic                   ser_en,
    output logic [5:0]             x_in,
    output logic                   stbi,
    output logic                   frame_err,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_HOLD,
        TX_STROBE,
        TX_GAP
    } tx_state_t;

    // Receiver state
    rx_state_t rx_state;
    rx_state_t rx_next;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_next;
    logic [5:0] rx_data;
    logic [5:0] rx_data_next;
    logic       par_err;
    logic       par_err_next;
    logic       rx_push;
    logic       rx_err;

    // FIFO state
    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;

    // Transmit pacing state
    tx_state_t     tx_state;
    tx_state_t     tx_next;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_next;
    logic          tx_pop;

    // Receiver next-state logic: the deframer only moves on bit-rate strobes.
    always_comb begin
        rx_next      = rx_state;
        bit_cnt_next = bit_cnt;
        rx_data_next = rx_data;
        par_err_next = par_err;
        rx_push      = 1'b0;
        rx_err       = 1'b0;
        if (ser_en) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!ser_in) begin
                        rx_next      = RX_DATA;
                        bit_cnt_next = 3'd0;
                        par_err_next = 1'b0;
                    end
                end
                RX_DATA: begin
                    rx_data_next[bit_cnt] = ser_in;
                    if (bit_cnt == 3'd5) begin
`ifdef PARITY_CHECK_EN
                        rx_next = RX_PAR;
`else
                        rx_next = RX_STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
`ifdef PARITY_CHECK_EN
                RX_PAR: begin
                    par_err_next = (^rx_data) ^ ser_in;
                    rx_next      = RX_STOP;
                end
`endif
                RX_STOP: begin
                    if (ser_in) begin
                        rx_next = RX_IDLE;
                        if (par_err) begin
                            rx_err = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end else begin
                        rx_err  = 1'b1;
                        rx_next = RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    if (ser_in) begin
                        rx_next = RX_IDLE;
                    end
                end
                default: begin
                    rx_next = RX_IDLE;
                end
            endcase
        end
    end

    // Receiver registers; frame_err is a registered copy of the error decision
    // so it is one clock wide regardless of how long ser_en stays high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state  <= RX_IDLE;
            bit_cnt   <= 3'd0;
            rx_data   <= 6'd0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            bit_cnt   <= bit_cnt_next;
            rx_data   <= rx_data_next;
            par_err   <= par_err_next;
            frame_err <= rx_err;
        end
    end

    // A full FIFO still accepts a word when the transmitter drains one on the same edge.
    assign push_ok = rx_push && ((fifo_level < LW'(DEPTH)) || tx_pop);

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !tx_pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (!push_ok && tx_pop) begin
                fifo_level <= fifo_level - 1'b1;
            end
            if (rx_push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmit pacing: pop in HOLD, one strobe cycle, then a high gap.
    // gap_cnt counts the remaining gap cycles; leaving TX_GAP on the edge it
    // would reach zero makes strobe-to-strobe spacing GAP+1 clocks, with stbi
    // high for GAP clocks in between.
    always_comb begin
        tx_next      = tx_state;
        gap_cnt_next = gap_cnt;
        tx_pop       = 1'b0;
        case (tx_state)
            TX_HOLD: begin
                if (fifo_level != '0) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_STROBE;
                end
            end
            TX_STROBE: begin
                tx_next      = TX_GAP;
                gap_cnt_next = GW'(GAP - 1);
            end
            TX_GAP: begin
                if (gap_cnt <= GW'(1)) begin
                    tx_next      = TX_HOLD;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt - 1'b1;
                end
            end
            default: begin
                tx_next = TX_HOLD;
            end
        endcase
    end

    // Transmit registers; x_in keeps the last word between strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state <= TX_HOLD;
            gap_cnt  <= '0;
            x_in     <= 6'd0;
            stbi     <= 1'b1;
        end else begin
            tx_state <= tx_next;
            gap_cnt  <= gap_cnt_next;
            stbi     <= ~tx_pop;
            if (tx_pop) begin
                x_in <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_b11_serial_feeder.sv
// Testbench for b11_serial_feeder: random and directed serial frames, with a
// timing-level reference model (push edge, pop edge per word) feeding a
// scoreboard that a separate monitor drains whenever the DUT strobes.
module tb_b11_serial_feeder;

    localparam int DEPTH = 4;
    localparam int GAP   = 32;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int BIG   = 32'h3fff_ffff;
`ifdef PARITY_CHECK_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ser_in = 1'b1;
    logic          ser_en = 1'b0;
    logic [5:0]    x_in;
    logic          stbi;
    logic          frame_err;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    b11_serial_feeder #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clock      (clock),
        .reset      (reset),
        .ser_in     (ser_in),
        .ser_en     (ser_en),
        .x_in       (x_in),
        .stbi       (stbi),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    // Edge counter: after posedge n it holds n.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int en_gap_max = 0;

    // One accepted word: edge it entered the FIFO, edge it was popped.
    typedef struct {
        int         push;
        int         pop;
        logic [5:0] w;
    } rec_t;

    rec_t recs[$];
    rec_t exp_q[$];
    int   err_q[$];
    int   last_pop = -100000;
    int   ovf_edge = BIG;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input string msg);
        checks++;
        errors++;
        $display("[TB] FAIL %s cycle %0d: %s", name, cyc, msg);
    endtask

    // Words still queued (popped strictly after edge t).
    function automatic int pending_after(input int t);
        int n = 0;
        foreach (recs[i]) if (recs[i].pop > t) n++;
        return n;
    endfunction

    // FIFO occupancy right after edge c.
    function automatic int model_level(input int c);
        int n = 0;
        foreach (recs[i]) if (recs[i].push <= c && recs[i].pop > c) n++;
        return n;
    endfunction

    // Reference model: a completed frame whose stop bit is sampled at edge t.
    task automatic model_frame(input int t, input logic [5:0] w, input bit good);
        rec_t r;
        int   d;
        if (!good) begin
            err_q.push_back(t);
        end else if (pending_after(t) < DEPTH) begin
            d = t + 1;
            if (last_pop + GAP + 1 > d) d = last_pop + GAP + 1;
            last_pop = d;
            r.push = t;
            r.pop  = d;
            r.w    = w;
            recs.push_back(r);
            exp_q.push_back(r);
        end else if (ovf_edge == BIG) begin
            ovf_edge = t;
        end
    endtask

    // Drive one clock of input; t is the edge that samples it.
    task automatic drive_bit(input logic b, input logic en, output int t);
        @(posedge clock);
        #2;
        ser_in = b;
        ser_en = en;
        t = cyc + 1;
    endtask

    task automatic send_bit(input logic b, output int t);
        int tt;
        repeat ($urandom_range(en_gap_max, 0)) drive_bit(1'($urandom % 2), 1'b0, tt);
        drive_bit(b, 1'b1, t);
    endtask

    task automatic apply_stimulus(input logic [5:0] w, input bit bad_par, input bit bad_stop);
        int t;
        send_bit(1'b0, t);
        for (int i = 0; i < 6; i++) send_bit(w[i], t);
        if (HAS_PAR) send_bit((^w) ^ bad_par, t);
        send_bit(~bad_stop, t);
        model_frame(t, w, !bad_stop && !(HAS_PAR && bad_par));
    endtask

    task automatic idle_line(input int n);
        int t;
        repeat (n) drive_bit(1'b1, 1'($urandom % 2), t);
    endtask

    // Reset held for two edges; pending expectations from the reset edge on are discarded.
    task automatic apply_reset();
        int   r;
        rec_t keep[$];
        int   keep_e[$];
        @(posedge clock);
        #2;
        reset  = 1'b0;
        ser_en = 1'b0;
        ser_in = 1'b1;
        r = cyc + 1;
        #4;
        keep = {};
        foreach (exp_q[i]) if (exp_q[i].pop < r) keep.push_back(exp_q[i]);
        exp_q = keep;
        keep = {};
        foreach (recs[i]) if (recs[i].pop < r) keep.push_back(recs[i]);
        recs = keep;
        keep_e = {};
        foreach (err_q[i]) if (err_q[i] < r) keep_e.push_back(err_q[i]);
        err_q = keep_e;
        last_pop = -100000;
        ovf_edge = BIG;
        mon_en   = 1'b1;
        @(negedge clock);
        check_output("reset_x_in", 32'(x_in), 32'd0);
        check_output("reset_stbi", 32'(stbi), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() > 0 || err_q.size() > 0) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() > 0 || err_q.size() > 0)
            report_fail("drain_timeout", $sformatf("%0d words and %0d errors still expected", exp_q.size(), err_q.size()));
        @(negedge clock);
    endtask

    // Monitor: pops the scoreboard on every strobe or error pulse and checks level/overflow each cycle.
    always @(negedge clock) begin
        int c;
        if (mon_en) begin
            c = cyc;
            while (exp_q.size() > 0 && exp_q[0].pop < c) begin
                report_fail("strobe_missing", $sformatf("no strobe at edge %0d, expected word %0h", exp_q[0].pop, exp_q[0].w));
                void'(exp_q.pop_front());
            end
            if (stbi === 1'b0) begin
                if (exp_q.size() > 0 && exp_q[0].pop == c) begin
                    check_output("strobe_word", 32'(x_in), 32'(exp_q[0].w));
                    void'(exp_q.pop_front());
                end else begin
                    report_fail("strobe_unexpected", $sformatf("stbi=0 with x_in=%0h, none expected", x_in));
                end
            end else if (stbi !== 1'b1) begin
                report_fail("stbi_unknown", $sformatf("stbi=%b", stbi));
            end
            while (err_q.size() > 0 && err_q[0] < c) begin
                report_fail("frame_err_missing", $sformatf("no pulse at edge %0d", err_q[0]));
                void'(err_q.pop_front());
            end
            if (frame_err === 1'b1) begin
                if (err_q.size() > 0 && err_q[0] == c) begin
                    checks++;
                    void'(err_q.pop_front());
                end else begin
                    report_fail("frame_err_unexpected", "pulse with none expected");
                end
            end else if (frame_err !== 1'b0) begin
                report_fail("frame_err_unknown", $sformatf("frame_err=%b", frame_err));
            end
            check_output("fifo_level", 32'(fifo_level), 32'(model_level(c)));
            check_output("overflow", 32'(overflow), 32'(c >= ovf_edge));
        end
    end

    // Hard stop so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        apply_reset();

        // Single word with a strobe every clock
        en_gap_max = 0;
        idle_line(3);
        apply_stimulus(6'h2A, 1'b0, 1'b0);
        idle_line(40);

        // Two words back to back, paced by the gap
        apply_stimulus(6'h05, 1'b0, 1'b0);
        apply_stimulus(6'h3F, 1'b0, 1'b0);
        idle_line(80);

        // Inverted parity bit (a normal word when parity is not built in)
        apply_stimulus(6'h11, 1'b1, 1'b0);
        idle_line(40);

        // Bad stop, line held low, then recovery
        apply_stimulus(6'h00, 1'b0, 1'b1);
        repeat (5) send_bit(1'b0, t);
        send_bit(1'b1, t);
        apply_stimulus(6'h1A, 1'b0, 1'b0);
        idle_line(40);

        // Burst that overruns the FIFO; overflow must stay set afterwards
        for (int i = 0; i < 7; i++) apply_stimulus(6'($urandom), 1'b0, 1'b0);
        wait_drain();
        idle_line(5);
        apply_reset();

        // Reset in the middle of a frame
        send_bit(1'b0, t);
        send_bit(1'b1, t);
        send_bit(1'b0, t);
        apply_reset();
        idle_line(2);
        apply_stimulus(6'h15, 1'b0, 1'b0);

        // Reset in the middle of the gap with a word still queued
        apply_stimulus(6'h2B, 1'b0, 1'b0);
        idle_line(5);
        apply_reset();
        idle_line(40);
        apply_stimulus(6'h33, 1'b0, 1'b0);

        // Randomized traffic with sparse bit strobes and occasional bad frames
        en_gap_max = 2;
        for (int i = 0; i < 25; i++) begin
            bit bp;
            bit bs;
            bp = ($urandom % 8) == 0;
            bs = ($urandom % 8) == 0;
            apply_stimulus(6'($urandom), bp, bs);
            if (bs) drive_bit(1'b1, 1'b1, t);
            idle_line($urandom_range(40, 0));
        end
        wait_drain();
        idle_line(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
